// File: rtl/seq_elem_sel_pkg.sv
// Shared types for the element-select serializer: the two-state transmit FSM.
package seq_elem_sel_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

endpackage

// File: rtl/seq_rhs_element_select_serializer.sv
// Parallel-to-serial transmitter: holds a word and emits hold[idx] LSB first,
// using a dynamic RHS bit select instead of a shift register.
module seq_rhs_element_select_serializer
  import seq_elem_sel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    idx_nxt   = idx;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    ser_out   = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_nxt  = in_data;
          idx_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_last  = (idx == LAST_IDX);
        ser_out   = hold[idx];
        // The last beat doubles as an accept slot so words stream with no gap.
        in_ready  = ser_last && ser_ready;
        if (ser_ready) begin
          if (!ser_last) begin
            idx_nxt = idx + IDX_W'(1);
          end else if (in_valid) begin
            hold_nxt = in_data;
            idx_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_rhs_element_select_serializer.sv
// Scoreboard bench: expected beats queued on each accepted word, compared per accepted beat.
module tb_seq_rhs_element_select_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_in_ready, a_ser_out, a_ser_valid, a_ser_last;
  logic       a_ser_ready = 1'b1, a_busy;
  logic [7:0] a_in_data = '0;
  logic       b_in_valid = 1'b0, b_in_ready, b_ser_out, b_ser_valid, b_ser_last;
  logic       b_ser_ready = 1'b1, b_busy;
  logic [4:0] b_in_data = '0;

  seq_rhs_element_select_serializer #(.WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
    .ser_last(a_ser_last), .ser_ready(a_ser_ready), .busy(a_busy));

  seq_rhs_element_select_serializer #(.WIDTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
    .ser_last(b_ser_last), .ser_ready(b_ser_ready), .busy(b_busy));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // {last, bit} per expected beat
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] ea, eb;

  always @(negedge clk) begin
    if (rst_n && a_ser_valid && a_ser_ready) begin
      if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_bit", a_ser_out, ea[0]);
        chk("a_last", a_ser_last, ea[1]);
      end
    end
    if (rst_n && a_in_valid && a_in_ready)
      for (int i = 0; i < 8; i++) qa.push_back({(i == 7), a_in_data[i]});
  end

  always @(negedge clk) begin
    if (rst_n && b_ser_valid && b_ser_ready) begin
      if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_bit", b_ser_out, eb[0]);
        chk("b_last", b_ser_last, eb[1]);
      end
    end
    if (rst_n && b_in_valid && b_in_ready)
      for (int i = 0; i < 5; i++) qb.push_back({(i == 4), b_in_data[i]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_in_ready"}, a_in_ready, 1);
    chk({tag, "_ser_valid"}, a_ser_valid, 0);
    chk({tag, "_ser_last"}, a_ser_last, 0);
    chk({tag, "_ser_out"}, a_ser_out, 0);
    chk({tag, "_busy"}, a_busy, 0);
  endtask

  initial begin
    // during reset
    #1;
    chk_a_idle("rst");
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_ser_valid", b_ser_valid, 0);
    tick(); tick();
    rst_n = 1'b1;

    // idle for 3 cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk_a_idle("idle");
      tick();
    end

    // single word A5
    a_in_valid = 1'b1; a_in_data = 8'hA5;
    tick();
    a_in_valid = 1'b0; a_in_data = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("single_valid", a_ser_valid, 1);
      chk("single_last_pos", a_ser_last, (i == 8));
      tick();
    end
    @(negedge clk); chk_a_idle("single_end");
    tick();

    // backpressure on bit 3 of 3C
    a_in_valid = 1'b1; a_in_data = 8'h3C;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    a_ser_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_valid", a_ser_valid, 1);
      chk("stall_bit3", a_ser_out, 1);
      chk("stall_last", a_ser_last, 0);
      tick();
      if (s == 1) a_ser_ready = 1'b1;
    end
    for (int c = 7; c <= 10; c++) begin
      @(negedge clk);
      chk("stall_valid_tail", a_ser_valid, 1);
      chk("stall_last_pos", a_ser_last, (c == 10));
      tick();
    end
    @(negedge clk); chk_a_idle("stall_end");
    tick();

    // back-to-back FF then 00
    a_in_valid = 1'b1; a_in_data = 8'hFF;
    tick();
    a_in_data = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("b2b_valid", a_ser_valid, 1);
      if (i <= 8) chk("b2b_in_ready", a_in_ready, (i == 8));
      tick();
      if (i == 8) a_in_valid = 1'b0;
    end
    @(negedge clk); chk_a_idle("b2b_end");
    tick();

    // async reset during bit 4 of 81
    a_in_valid = 1'b1; a_in_data = 8'h81;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("mid_bit4_valid", a_ser_valid, 1);
    chk("mid_bit4_out", a_ser_out, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("mid_rst_ser_valid", a_ser_valid, 0);
    chk("mid_rst_in_ready", a_in_ready, 1);
    chk("mid_rst_busy", a_busy, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk); chk_a_idle("post_rst");
    tick();
    a_in_valid = 1'b1; a_in_data = 8'h01;
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_bit0", a_ser_out, 1);
    for (int i = 1; i <= 8; i++) tick();
    @(negedge clk); chk_a_idle("post_rst_end");
    tick();

    // WIDTH=5 word 10011
    b_in_valid = 1'b1; b_in_data = 5'b10011;
    tick();
    b_in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("w5_valid", b_ser_valid, 1);
      chk("w5_last_pos", b_ser_last, (i == 5));
      tick();
    end
    @(negedge clk);
    chk("w5_end_valid", b_ser_valid, 0);
    chk("w5_end_busy", b_busy, 0);
    chk("w5_end_in_ready", b_in_ready, 1);
    tick();

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_rhs_element_select_serializer.md
# seq_rhs_element_select_serializer

Parallel-to-serial transmitter benchmark for the SystemVerilog frontend's sequential extraction. It accepts a WIDTH-bit word over a valid/ready handshake, holds it in a register, and shifts it out LSB first, one bit per accepted serial beat. Each serial bit is selected with a dynamically indexed element-select on the right-hand side (`hold[idx]`); no shift register is used. This is the read side of per-bit element-select register access and complements the deserializer-style benchmarks that write single bits on the LHS.

## Interface

Parameters:
- WIDTH, default 8, word width; must be at least 2.
- IDX_W, default $clog2(WIDTH), width of the bit index.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  the word on in_data is offered.
- in_ready  output  1  the block can accept a word this cycle.
- in_data  input  WIDTH  parallel word; sampled only on the accept edge.
- ser_out  output  1  current serial bit, equal to hold[idx].
- ser_valid  output  1  ser_out is a valid beat.
- ser_last  output  1  the current beat is bit WIDTH-1 of the word.
- ser_ready  input  1  downstream accepts the current beat.
- busy  output  1  a word is in flight (state is SHIFT).

## Operation

- State machine, two states:
  - IDLE:
    - in_ready=1.
    - On in_valid: load hold<=in_data, set idx<=0, go to SHIFT.
  - SHIFT:
    - Drive ser_valid=1, ser_out=hold[idx], ser_last=(idx==WIDTH-1).
    - On ser_ready with !ser_last: idx<=idx+1.
    - On ser_ready with ser_last: the word is complete.
      - If in_valid: reload hold and set idx<=0; stay in SHIFT (gapless back-to-back).
      - Otherwise: go to IDLE.
    - With ser_ready=0: hold all state; ser_out, ser_valid and ser_last stay stable.
- Combinational outputs:
  - in_ready = (state==IDLE) || (ser_valid && ser_last && ser_ready).
  - busy = (state==SHIFT).
- In IDLE: ser_valid=0, ser_last=0, ser_out=0 (forced to 0, not hold[idx]).
- idx never exceeds WIDTH-1. There is no wrap-around through out-of-range indices, including when WIDTH is not a power of 2.
- Reset values:
  - state=IDLE, hold=0, idx=0.
  - Outputs during and immediately after reset: in_ready=1, ser_valid=0, ser_last=0, ser_out=0, busy=0.
- Reset asserted mid-word aborts the word immediately and asynchronously. The remaining bits are dropped and never replayed.

## Timing

- A word is accepted at the rising edge where in_valid && in_ready.
- Bit 0 appears on ser_out in the cycle after acceptance.
- With ser_ready held at 1, bits 0..WIDTH-1 occupy WIDTH consecutive cycles. ser_last is high in the last of those cycles.
- Sustained throughput is one word per WIDTH cycles with no idle gap when in_valid is asserted during the ser_last beat.
- A deasserted ser_ready extends the current beat by one cycle per stall cycle.
- in_data is not required to be stable after the accept edge.

## Structure

- Shared package seq_elem_sel_pkg:
  - typedef enum logic {IDLE, SHIFT} ser_state_t.
  - No other constants.
- Single module with no sub-module. The index counter and state register sit in one always_ff with asynchronous reset on negedge rst_n.
- Output decode is in always_comb.

## Test plan

- Reset, then idle:
  - Stimulus: drive in_valid=0 for 3 cycles.
  - Required: in_ready=1, ser_valid=0, ser_out=0, busy=0 throughout.
- Single word, WIDTH=8:
  - Stimulus: in_data=8'hA5 accepted at cycle 0; ser_ready=1.
  - Required: cycles 1-8 show ser_out=1,0,1,0,0,1,0,1, with ser_last only in cycle 8; IDLE in cycle 9.
- Backpressure:
  - Stimulus: word 8'h3C; ser_ready=0 for 2 cycles at bit 3.
  - Required: ser_out holds 1 (bit 3) for 3 cycles; the remaining bits are unchanged; ser_last arrives 2 cycles later than in the unstalled case.
- Back-to-back:
  - Stimulus: 8'hFF followed by 8'h00, with in_valid held high.
  - Required: second word accepted on the ser_last beat; 16 contiguous valid beats (8 ones, then 8 zeros) with no gap.
- Reset mid-word:
  - Stimulus: word 8'h81; assert rst_n=0 asynchronously during bit 4.
  - Required: ser_valid=0 and in_ready=1 immediately; after release, a new word 8'h01 transmits from bit 0.
- Non-power-of-2 width:
  - Stimulus: WIDTH=5, word 5'b10011.
  - Required: beats 1,1,0,0,1; idx stays within 0..4; ser_last on the 5th beat.
